series_accumulator: RTL and testbench
=====================================

Name: series_accumulator

Overview:
- Parametrised next-generation series adder: sums term(i) for i = lo, lo+step, ..., up to and including hi.
- term(i) = i (mode 0) or i*i (mode 1).
- Processes one term per clock and reports the result with the same start/done level handshake the team uses for sequential arithmetic blocks.
- Adds over the previous generation: configurable range and step, a squares mode, overflow detection, abort, and a busy flag.

Parameters:
- DATA_W, 8, width of lo/hi/step operands (unsigned).
- ACC_W, 24, accumulator and sum_out width; must be >= DATA_W, and >= 2*DATA_W when squares are used.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level request; sampled in IDLE; must stay high until done is seen.
- abort  in  1  cancels a calculation in progress.
- mode  in  1  0 = sum of i, 1 = sum of i*i.
- lo  in  DATA_W  first index (unsigned).
- hi  in  DATA_W  last allowed index (unsigned, inclusive).
- step  in  DATA_W  index increment; 0 is treated as 1.
- busy  out  1  high while in CALC.
- done  out  1  high while in DONE.
- overflow  out  1  valid with done; accumulator wrapped at least once.
- sum_out  out  ACC_W  result while done; 0 otherwise.

Behaviour:
- Reset (async, rst=1): state IDLE, acc=0, idx=0, ovf=0. Outputs busy=0, done=0, overflow=0, sum_out=0. Reset mid-calculation discards all work; with start still high after release, a new run begins from IDLE on the next sampled edge.
- States: IDLE, CALC, DONE, encoded in 2 bits.
- IDLE, start=1 at a clock edge:
  - Latch mode, lo, hi, and step (0 becomes 1) into internal registers. Inputs are not observed again until the next IDLE.
  - Clear acc and ovf; set idx=lo.
  - If lo > hi, go straight to DONE with sum 0. Otherwise go to CALC.
- CALC, each cycle:
  - acc <= acc + term(idx), computed at ACC_W+1 bits. The carry-out ORs into the sticky ovf, and acc keeps the low ACC_W bits (modulo 2^ACC_W).
  - term(idx) is zero-extended to ACC_W. In mode 1 the square is 2*DATA_W bits, truncated to ACC_W if ACC_W < 2*DATA_W, and truncation also sets ovf.
  - idx <= idx + step, computed at DATA_W+1 bits so the index never wraps.
  - If idx + step > hi (compared at DATA_W+1 bits), this is the last term and the next state is DONE.
- Latency: N = floor((hi-lo)/step)+1 terms take N CALC cycles. done rises at edge N+1 after start is sampled, or at edge 1 for an empty range.
- abort=1 in CALC: return to IDLE next edge and clear acc. done is not asserted. abort has priority over last-term completion in the same cycle. abort is ignored in IDLE and DONE.
- DONE: hold acc and ovf. done=1, sum_out=acc, overflow=ovf. Return to IDLE on the first edge with start=0. start staying high keeps the block in DONE; there is no auto-restart.
- Outputs are decoded from the registered state (busy = CALC, done = DONE) and gate sum_out/overflow to 0 outside DONE. No combinational path exists from inputs to outputs.
- Illegal state encoding returns to IDLE.

Decomposition:
- Shared package series_pkg: state enum (S_IDLE=2'b00, S_CALC=2'b01, S_DONE=2'b10), mode constants MODE_SUM=1'b0 and MODE_SQR=1'b1.
- One natural sub-module, series_term: purely combinational idx,mode -> term plus a truncation flag, parametrised by DATA_W/ACC_W. Kept separate so a pipelined multiplier can replace it later.
- FSM and datapath stay in series_accumulator.

Test Plan:
- Default params, mode 0, lo=1, hi=10, step=1, start held -> busy for 10 cycles; done=1 at edge 11; sum_out=55, overflow=0. Dropping start returns to IDLE, where done=0 and sum_out=0.
- Mode 1, lo=1, hi=10, step=1 -> sum_out=385 after 10 CALC cycles. Mode 0, lo=1, hi=10, step=2 -> 25 after 5 cycles. step=0 on the same range -> 55 (step treated as 1).
- Edge ranges:
  - lo=5, hi=5 -> 5 after 1 CALC cycle.
  - lo=9, hi=3 -> done at edge 1, sum_out=0, busy never high.
  - lo=250, hi=255, step=4 -> 250+254=504; idx steps to 258 without wrapping.
- ACC_W=8, mode 0, lo=1, hi=30 -> done after 30 cycles, overflow=1, sum_out=465 mod 256=209. ACC_W=8, mode 1, lo=16, hi=16 -> overflow=1, sum_out=0.
- abort at CALC cycle 4 of 1..10 -> IDLE next edge, done never asserted. Restart -> 55. Abort coincident with the last term -> IDLE, not DONE.
- rst pulsed mid-CALC (asynchronously, between edges) -> outputs 0 immediately. With start still high after release -> fresh run yields 55, with no residue from the interrupted run.

Source files
------------

// File: rtl/series_pkg.sv
// Shared types and constants for the series accumulator and its term generator.
package series_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_SQR = 1'b1;

endpackage

// File: rtl/series_term.sv
// Combinational term generator: i or i*i, zero-extended to ACC_W.
// trunc flags a square whose upper bits did not fit the accumulator width.
module series_term
    import series_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              mode,
    input  logic [DATA_W-1:0] idx,
    output logic [ACC_W-1:0]  term,
    output logic              trunc
);

    logic [2*DATA_W-1:0] sq;
    logic [ACC_W-1:0]    term_sq;
    logic                trunc_sq;

    assign sq = (2*DATA_W)'(idx) * (2*DATA_W)'(idx);

    generate
        if (ACC_W >= 2*DATA_W) begin : g_wide
            assign term_sq  = ACC_W'(sq);
            assign trunc_sq = 1'b0;
        end else begin : g_narrow
            assign term_sq  = sq[ACC_W-1:0];
            assign trunc_sq = |sq[2*DATA_W-1:ACC_W];
        end
    endgenerate

    assign term  = (mode == MODE_SQR) ? term_sq : ACC_W'(idx);
    assign trunc = (mode == MODE_SQR) && trunc_sq;

endmodule

// File: rtl/series_accumulator.sv
// Sums term(i) for i = lo, lo+step, ... <= hi, one term per clock, with a
// start/done level handshake, sticky overflow, abort and busy.
module series_accumulator
    import series_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] step,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ACC_W-1:0]  sum_out
);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q;
    logic [DATA_W:0]     idx_q;
    logic                ovf_q;
    logic                mode_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   step_q;

    logic [ACC_W-1:0]    term;
    logic                trunc;
    logic [ACC_W:0]      acc_sum;
    logic [DATA_W:0]     idx_nxt;
    logic                last_term;

    series_term #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_term (
        .mode  (mode_q),
        .idx   (idx_q[DATA_W-1:0]),
        .term  (term),
        .trunc (trunc)
    );

    // One extra bit on both sums: carry feeds overflow, and idx can pass hi without wrapping
    assign acc_sum   = {1'b0, acc_q} + {1'b0, term};
    assign idx_nxt   = idx_q + {1'b0, step_q};
    assign last_term = idx_nxt > {1'b0, hi_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (!start)        state_d = S_IDLE;
                else if (lo > hi)  state_d = S_DONE;
                else               state_d = S_CALC;
            end
            S_CALC: begin
                if (abort)          state_d = S_IDLE;
                else if (last_term) state_d = S_DONE;
                else                state_d = S_CALC;
            end
            S_DONE:  state_d = start ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            idx_q  <= '0;
            ovf_q  <= 1'b0;
            mode_q <= MODE_SUM;
            hi_q   <= '0;
            step_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        idx_q  <= {1'b0, lo};
                        mode_q <= mode;
                        hi_q   <= hi;
                        step_q <= (step == '0) ? DATA_W'(1) : step;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        acc_q <= '0;
                    end else begin
                        acc_q <= acc_sum[ACC_W-1:0];
                        ovf_q <= ovf_q | acc_sum[ACC_W] | trunc;
                        idx_q <= idx_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q == S_CALC);
    assign done     = (state_q == S_DONE);
    assign overflow = done & ovf_q;
    assign sum_out  = done ? acc_q : '0;

endmodule

// File: tb/tb_series_accumulator.sv
module tb_series_accumulator;

    logic        clk;
    logic        rst;

    logic        start1, abort1, mode1;
    logic [7:0]  lo1, hi1, step1;
    logic        busy1, done1, ovf1;
    logic [23:0] sum1;

    logic        start2, abort2, mode2;
    logic [7:0]  lo2, hi2, step2;
    logic        busy2, done2, ovf2;
    logic [7:0]  sum2;

    int checks = 0;
    int errors = 0;

    series_accumulator #(.DATA_W(8), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .mode(mode1),
        .lo(lo1), .hi(hi1), .step(step1),
        .busy(busy1), .done(done1), .overflow(ovf1), .sum_out(sum1)
    );

    series_accumulator #(.DATA_W(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .mode(mode2),
        .lo(lo2), .hi(hi2), .step(step2),
        .busy(busy2), .done(done2), .overflow(ovf2), .sum_out(sum2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input bit sel, input logic m, input logic [7:0] l,
                            input logic [7:0] h, input logic [7:0] s);
        @(negedge clk);
        if (sel) begin
            mode2 = m; lo2 = l; hi2 = h; step2 = s; start2 = 1'b1;
        end else begin
            mode1 = m; lo1 = l; hi1 = h; step1 = s; start1 = 1'b1;
        end
    endtask

    // Counts edges until done (edges = -1 if the budget runs out) and busy cycles seen.
    task automatic wait_done(input bit sel, output int edges, output int busy_cnt);
        bit seen;
        edges = -1;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (sel ? busy2 : busy1) busy_cnt++;
            if (sel ? done2 : done1) begin
                edges = i;
                seen = 1'b1;
            end
        end
    endtask

    task automatic drop_start;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy1, done1, ovf1, sum1} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b ovf=%0b sum=%0d, want all 0",
                     busy1, done1, ovf1, sum1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy1, done1, busy2, done2} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%0b done=%0b, want 0 0", busy1, done1);
        end
    endtask

    task automatic run_case(input string name, input logic m, input logic [7:0] l,
                            input logic [7:0] h, input logic [7:0] s,
                            input int exp_n, input logic [23:0] exp_sum);
        int e, b;
        do_start(1'b0, m, l, h, s);
        wait_done(1'b0, e, b);
        checks++;
        if (e !== exp_n + 1 || b !== exp_n) begin
            errors++;
            $display("FAIL %s_latency: got done at edge %0d busy %0d cycles, want edge %0d busy %0d",
                     name, e, b, exp_n + 1, exp_n);
        end
        checks++;
        if (sum1 !== exp_sum || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_sum: got sum=%0d ovf=%0b, want sum=%0d ovf=0",
                     name, sum1, ovf1, exp_sum);
        end
        drop_start();
    endtask

    task automatic test_basic_sum;
        int e, b;
        do_start(1'b0, 1'b0, 8'd1, 8'd10, 8'd1);
        wait_done(1'b0, e, b);
        checks++;
        if (e !== 11 || b !== 10) begin
            errors++;
            $display("FAIL basic_latency: got done at edge %0d busy %0d, want edge 11 busy 10", e, b);
        end
        checks++;
        if (sum1 !== 24'd55 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: got sum=%0d ovf=%0b, want 55 0", sum1, ovf1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 24'd55) begin
            errors++;
            $display("FAIL done_hold: got done=%0b busy=%0b sum=%0d, want 1 0 55", done1, busy1, sum1);
        end
        drop_start();
        checks++;
        if (done1 !== 1'b0 || sum1 !== 24'd0) begin
            errors++;
            $display("FAIL return_idle: got done=%0b sum=%0d, want 0 0", done1, sum1);
        end
    endtask

    task automatic test_modes;
        run_case("squares", 1'b1, 8'd1, 8'd10, 8'd1, 10, 24'd385);
        run_case("step2", 1'b0, 8'd1, 8'd10, 8'd2, 5, 24'd25);
        run_case("step0", 1'b0, 8'd1, 8'd10, 8'd0, 10, 24'd55);
        run_case("single", 1'b0, 8'd5, 8'd5, 8'd1, 1, 24'd5);
        run_case("top_range", 1'b0, 8'd250, 8'd255, 8'd4, 2, 24'd504);
    endtask

    task automatic test_empty_range;
        int e, b;
        do_start(1'b0, 1'b0, 8'd9, 8'd3, 8'd1);
        wait_done(1'b0, e, b);
        checks++;
        if (e !== 1 || b !== 0 || sum1 !== 24'd0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL empty_range: got edge %0d busy %0d sum=%0d ovf=%0b, want 1 0 0 0",
                     e, b, sum1, ovf1);
        end
        drop_start();
    endtask

    task automatic test_overflow;
        int e, b;
        do_start(1'b1, 1'b0, 8'd1, 8'd30, 8'd1);
        wait_done(1'b1, e, b);
        checks++;
        if (e !== 31 || sum2 !== 8'd209 || ovf2 !== 1'b1) begin
            errors++;
            $display("FAIL acc_wrap: got edge %0d sum=%0d ovf=%0b, want 31 209 1", e, sum2, ovf2);
        end
        drop_start();
        do_start(1'b1, 1'b1, 8'd16, 8'd16, 8'd1);
        wait_done(1'b1, e, b);
        checks++;
        if (e !== 2 || sum2 !== 8'd0 || ovf2 !== 1'b1) begin
            errors++;
            $display("FAIL sq_trunc: got edge %0d sum=%0d ovf=%0b, want 2 0 1", e, sum2, ovf2);
        end
        drop_start();
    endtask

    task automatic test_abort;
        int seen_done;
        do_start(1'b0, 1'b0, 8'd1, 8'd10, 8'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort1 = 1'b1;
        start1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_mid: got busy=%0b done=%0b, want 0 0", busy1, done1);
        end
        @(negedge clk);
        abort1 = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got done for %0d cycles, want 0", seen_done);
        end
        run_case("after_abort", 1'b0, 8'd1, 8'd10, 8'd1, 10, 24'd55);

        do_start(1'b0, 1'b0, 8'd5, 8'd5, 8'd1);
        @(posedge clk);
        @(negedge clk);
        abort1 = 1'b1;
        start1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_last: got busy=%0b done=%0b, want 0 0", busy1, done1);
        end
        @(negedge clk);
        abort1 = 1'b0;
    endtask

    task automatic test_async_reset;
        int e, b;
        do_start(1'b0, 1'b0, 8'd1, 8'd10, 8'd1);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 24'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%0b done=%0b sum=%0d, want 0 0 0", busy1, done1, sum1);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_done(1'b0, e, b);
        checks++;
        if (e !== 11 || sum1 !== 24'd55 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL rerun_after_reset: got edge %0d sum=%0d ovf=%0b, want 11 55 0", e, sum1, ovf1);
        end
        drop_start();
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; mode1 = 1'b0; lo1 = '0; hi1 = '0; step1 = '0;
        start2 = 1'b0; abort2 = 1'b0; mode2 = 1'b0; lo2 = '0; hi2 = '0; step2 = '0;
        test_reset();
        test_basic_sum();
        test_modes();
        test_empty_range();
        test_overflow();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
